// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg : shared MIPS core types and constants
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int          INST_WIDTH  = 32;
  localparam logic [5:0]  HALT_OPCODE = 6'b101101;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if : loader, memory port and decode-side signals of the fetch controller
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

interface imem_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  stall;
  logic                  branch_taken;
  logic [31:0]           branch_target;
  logic [31:0]           mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [31:0]           pc_out;
  logic                  inst_valid;
  logic                  halted;
  logic                  fault;

  modport master (
    input  load_valid, load_data, load_done, stall, branch_taken, branch_target, mem_rdata,
    output load_ready, mem_addr, mem_we, mem_wdata, inst_out, pc_out, inst_valid, halted, fault
  );

  modport slave (
    output load_valid, load_data, load_done, stall, branch_taken, branch_target, mem_rdata,
    input  load_ready, mem_addr, mem_we, mem_wdata, inst_out, pc_out, inst_valid, halted, fault
  );

endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl : instruction memory sequencer (boot loader writes, PC fetch, HALT)
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_SIZE   = 64,
  parameter int DATA_WIDTH = INST_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_fetch_ctrl_if.master    bus
);

  localparam int PTR_W = $clog2(MEM_SIZE + 1);

  fetch_state_t          state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [PTR_W-1:0]      load_ptr_q, load_ptr_d;
  logic [PTR_W-1:0]      load_count_q, load_count_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           pc_out_q, pc_out_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic                  load_ready_w;
  logic                  xfer_w;
  logic [31:0]           load_addr_w;
  logic [31:0]           pc_limit_w;

  assign load_ready_w = (state_q == LOAD) && (load_ptr_q < PTR_W'(MEM_SIZE));
  assign xfer_w       = load_ready_w && bus.load_valid;
  assign load_addr_w  = {{(30-PTR_W){1'b0}}, load_ptr_q, 2'b00};
  assign pc_limit_w   = {{(30-PTR_W){1'b0}}, load_count_q, 2'b00};

  assign bus.load_ready = load_ready_w;
  assign bus.mem_we     = xfer_w;
  assign bus.mem_wdata  = bus.load_data;
  assign bus.mem_addr   = (state_q == LOAD) ? load_addr_w : pc_q;
  assign bus.inst_out   = inst_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.inst_valid = valid_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    fault_d      = fault_q;

    unique case (state_q)
      LOAD: begin
        if (xfer_w) load_ptr_d = load_ptr_q + 1'b1;
        if (bus.load_done) begin
          state_d      = RUN;
          pc_d         = '0;
          load_count_d = xfer_w ? load_ptr_q + 1'b1 : load_ptr_q;
        end
      end
      RUN: begin
        if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          if (bus.branch_target[1:0] != 2'b00) begin
            state_d  = HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
          end
        end else if (!bus.stall) begin
          if (pc_q >= pc_limit_w) begin
            state_d  = HALT;
            halted_d = 1'b1;
            fault_d  = 1'b1;
            valid_d  = 1'b0;
          end else begin
            inst_d   = bus.mem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            // The HALT word itself is still handed to decode for one cycle
            if (bus.mem_rdata[DATA_WIDTH-1 -: 6] == HALT_OPCODE) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      pc_q         <= '0;
      load_ptr_q   <= '0;
      load_count_q <= '0;
      inst_q       <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl : directed self-checking bench for imem_fetch_ctrl
// Rev 1.0  : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_imem_fetch_ctrl;
  import mips_pkg::*;

  localparam logic [31:0] HALT_W = 32'hB400_0000;
  localparam logic [31:0] PROG_B = 32'h2000_0000;

  logic clk;
  logic reset;
  int   n_err;
  int   n_chk;
  int   wr_cnt;
  int   wr0_cnt;
  logic [31:0] mem [64];

  imem_fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

  imem_fetch_ctrl #(.MEM_SIZE(64), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural instruction memory with combinational read
  assign bus.mem_rdata = (bus.mem_addr < 32'd256) ? mem[bus.mem_addr[7:2]] : 32'h0;

  initial begin
    wr_cnt  = 0;
    wr0_cnt = 0;
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_cnt  = wr_cnt + 1;
      if (bus.mem_addr == 32'h0) wr0_cnt = wr0_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.load_done     = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  // Loads n words then pulses load_done alone; RUN is entered on the load_done edge
  task automatic load_prog(input int n, input bit halt_last);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = (halt_last && i == n-1) ? HALT_W : PROG_B + 32'(i);
      step();
    end
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b1;
    step();
    bus.load_done  = 1'b0;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    reset = 1'b0;

    // Reset state, then 4-word program ending in HALT with load_done on last word
    do_reset();
    check("rst_valid",  32'(bus.inst_valid), 32'd0);
    check("rst_halted", 32'(bus.halted),     32'd0);
    check("rst_fault",  32'(bus.fault),      32'd0);
    check("rst_pc_out", bus.pc_out,          32'd0);
    check("rst_inst",   bus.inst_out,        32'd0);
    check("rst_ready",  32'(bus.load_ready), 32'd1);
    check("rst_we",     32'(bus.mem_we),     32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = (i == 3) ? HALT_W : PROG_B + 32'(i);
      bus.load_done  = (i == 3);
      #1;
      check("ld_we",   32'(bus.mem_we), 32'd1);
      check("ld_addr", bus.mem_addr,    32'(i*4));
      step();
    end
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
    #1;
    check("run0_addr",  bus.mem_addr,        32'd0);
    check("run0_ready", 32'(bus.load_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", 32'(bus.inst_valid), 32'd1);
      check("t1_pc",    bus.pc_out,          32'(k*4));
      check("t1_inst",  bus.inst_out,        (k == 3) ? HALT_W : PROG_B + 32'(k));
    end
    check("t1_halted", 32'(bus.halted), 32'd1);
    check("t1_fault",  32'(bus.fault),  32'd0);
    step();
    check("t1_valid_off", 32'(bus.inst_valid), 32'd0);
    check("t1_halt_hold", 32'(bus.halted),     32'd1);

    // Overfill: 66 offered words, only 64 accepted, no wrap to address 0
    do_reset();
    begin
      int wb, w0b;
      wb  = wr_cnt;
      w0b = wr0_cnt;
      for (int i = 0; i < 66; i++) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hA000_0000 + 32'(i);
        #1;
        if (i == 64) begin
          check("full_ready", 32'(bus.load_ready), 32'd0);
          check("full_we",    32'(bus.mem_we),     32'd0);
        end
        step();
      end
      bus.load_valid = 1'b0;
      check("full_writes", 32'(wr_cnt - wb),   32'd64);
      check("full_wr0",    32'(wr0_cnt - w0b), 32'd1);
      check("full_mem0",   mem[0],             32'hA000_0000);
      check("full_mem63",  mem[63],            32'hA000_003F);
    end

    // 8-word program with a 3-cycle stall while pc=8
    do_reset();
    load_prog(8, 1'b1);
    step();
    check("st_pc0", bus.pc_out, 32'd0);
    step();
    check("st_pc4", bus.pc_out, 32'd4);
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check("st_hold_pc",    bus.pc_out,          32'd4);
      check("st_hold_inst",  bus.inst_out,        PROG_B + 32'd1);
      check("st_hold_valid", 32'(bus.inst_valid), 32'd1);
    end
    bus.stall = 1'b0;
    for (int k = 2; k < 8; k++) begin
      step();
      check("st_seq_pc",   bus.pc_out,   32'(k*4));
      check("st_seq_inst", bus.inst_out, (k == 7) ? HALT_W : PROG_B + 32'(k));
    end
    check("st_halted", 32'(bus.halted), 32'd1);

    // Branch to 0x10 with stall also high while pc=4: branch wins, one bubble
    do_reset();
    load_prog(8, 1'b1);
    step();
    check("br_pc0", bus.pc_out, 32'd0);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h10;
    step();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    check("br_bubble", 32'(bus.inst_valid), 32'd0);
    step();
    check("br_valid", 32'(bus.inst_valid), 32'd1);
    check("br_pc",    bus.pc_out,          32'h10);
    check("br_inst",  bus.inst_out,        PROG_B + 32'd4);

    // Fetch past the loaded program
    do_reset();
    load_prog(3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("oob_pc", bus.pc_out, 32'(k*4));
    end
    step();
    check("oob_halted", 32'(bus.halted),     32'd1);
    check("oob_fault",  32'(bus.fault),      32'd1);
    check("oob_valid",  32'(bus.inst_valid), 32'd0);

    // Misaligned branch target
    do_reset();
    load_prog(3, 1'b0);
    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h6;
    step();
    bus.branch_taken = 1'b0;
    check("mis_halted", 32'(bus.halted),     32'd1);
    check("mis_fault",  32'(bus.fault),      32'd1);
    check("mis_valid",  32'(bus.inst_valid), 32'd0);

    // Empty program faults on the first RUN cycle
    do_reset();
    load_prog(0, 1'b0);
    step();
    check("empty_fault", 32'(bus.fault), 32'd1);

    // Asynchronous reset mid-RUN at pc=8
    do_reset();
    load_prog(8, 1'b1);
    step();
    step();
    check("ar_pc4", bus.pc_out, 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid",  32'(bus.inst_valid), 32'd0);
    check("ar_pc_out", bus.pc_out,          32'd0);
    check("ar_inst",   bus.inst_out,        32'd0);
    check("ar_halted", 32'(bus.halted),     32'd0);
    step();
    reset = 1'b0;
    #1;
    check("ar_ready", 32'(bus.load_ready), 32'd1);
    check("ar_addr",  bus.mem_addr,        32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
